// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU pipeline: controller state encoding and PC source selects.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HALTED  = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_JR     = 2'b11;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: freezes on data-memory waits, flushes on
// redirects, stalls on load-use, and drains the pipe on a halt instruction.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        memtoReg_MEM,
  input  logic        memWr_MEM,
  input  logic        memtoReg_EX,
  input  logic [4:0]  rt_EX,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic [1:0]  PC_Src_MEM,
  input  logic        zero_MEM,
  input  logic        halt_MEM,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        halt,
  output logic [15:0] stall_cnt
);

  ctrl_state_t state_reg;
  logic        drain_cnt_reg;
  logic        redirect_pend_reg;
  logic [15:0] stall_cnt_reg;

  logic       mem_busy, redirect_now, redirect, load_use;
  logic       pc_en_c, halt_c;
  logic [3:0] en_c, flush_c;   // bit 0 IF/ID, 1 ID/EX, 2 EX/MEM, 3 MEM/WB

  always_comb begin : hazard_detect
    mem_busy     = (memtoReg_MEM | memWr_MEM) & ~dhit;
    redirect_now = (PC_Src_MEM == PC_BRANCH && zero_MEM) ||
                   PC_Src_MEM == PC_JUMP || PC_Src_MEM == PC_JR;
    redirect     = redirect_now | redirect_pend_reg;
    load_use     = memtoReg_EX && (rt_EX != 5'd0) &&
                   (rt_EX == rs_ID || rt_EX == rt_ID);
  end

  always_comb begin : latch_ctrl
    pc_en_c = 1'b0;
    halt_c  = 1'b0;
    en_c    = 4'b0000;
    flush_c = 4'b0000;
    case (state_reg)
      ST_RUN, ST_MEMWAIT: begin
        if (!mem_busy) begin
          if (halt_MEM) begin
            en_c    = 4'b1000;
            flush_c = 4'b0111;
          end else if (redirect) begin
            pc_en_c = 1'b1;
            en_c    = 4'b1111;
            flush_c = 4'b0111;
          end else if (load_use) begin
            en_c    = 4'b1100;
            flush_c = 4'b0010;
          end else if (!ihit) begin
            en_c    = 4'b1110;
            flush_c = 4'b0001;
          end else begin
            pc_en_c = 1'b1;
            en_c    = 4'b1111;
          end
        end
      end
      ST_DRAIN: begin
        en_c    = 4'b1000;
        flush_c = 4'b0111;
      end
      ST_HALTED: halt_c = 1'b1;
      default: ;
    endcase
  end

  // A flushed latch ignores its enable; reset silences every control at once.
  assign pc_en       = pc_en_c & ~RST;
  assign halt        = halt_c & ~RST;
  assign ifid_flush  = flush_c[0] & ~RST;
  assign idex_flush  = flush_c[1] & ~RST;
  assign exmem_flush = flush_c[2] & ~RST;
  assign memwb_flush = flush_c[3] & ~RST;
  assign ifid_en     = en_c[0] & ~flush_c[0] & ~RST;
  assign idex_en     = en_c[1] & ~flush_c[1] & ~RST;
  assign exmem_en    = en_c[2] & ~flush_c[2] & ~RST;
  assign memwb_en    = en_c[3] & ~flush_c[3] & ~RST;
  assign stall_cnt   = stall_cnt_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg         <= ST_RUN;
      drain_cnt_reg     <= 1'b0;
      redirect_pend_reg <= 1'b0;
      stall_cnt_reg     <= 16'd0;
    end else begin
      if ((state_reg == ST_RUN || state_reg == ST_MEMWAIT) && !pc_en_c &&
          stall_cnt_reg != 16'hFFFF)
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      case (state_reg)
        ST_RUN, ST_MEMWAIT: begin
          if (mem_busy) begin
            // Remember a redirect seen while frozen so it is acted on at dhit.
            state_reg         <= ST_MEMWAIT;
            redirect_pend_reg <= redirect_pend_reg | redirect_now;
          end else begin
            redirect_pend_reg <= 1'b0;
            drain_cnt_reg     <= 1'b0;
            state_reg         <= halt_MEM ? ST_DRAIN : ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg) state_reg <= ST_HALTED;
          else               drain_cnt_reg <= 1'b1;
        end
        default: state_reg <= state_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, memtoReg_MEM, memWr_MEM, memtoReg_EX;
  logic [4:0]  rt_EX, rs_ID, rt_ID;
  logic [1:0]  PC_Src_MEM;
  logic        zero_MEM, halt_MEM;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .memtoReg_MEM(memtoReg_MEM), .memWr_MEM(memWr_MEM),
    .memtoReg_EX(memtoReg_EX), .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .PC_Src_MEM(PC_Src_MEM), .zero_MEM(zero_MEM), .halt_MEM(halt_MEM),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt)
  );

  // Output word: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  //               exmem_en, exmem_flush, memwb_en, memwb_flush, halt}
  localparam logic [9:0] O_NONE   = 10'b0000000000;
  localparam logic [9:0] O_NORMAL = 10'b1101010100;
  localparam logic [9:0] O_LDUSE  = 10'b0000110100;
  localparam logic [9:0] O_REDIR  = 10'b1010101100;
  localparam logic [9:0] O_NOIHIT = 10'b0011010100;
  localparam logic [9:0] O_DRAIN  = 10'b0010101100;
  localparam logic [9:0] O_HALTED = 10'b0000000001;

  typedef struct {
    logic       ihit, dhit, mtr_mem, mw_mem, mtr_ex;
    logic [4:0] rt_ex, rs_id, rt_id;
    logic [1:0] pcsrc;
    logic       zero, halt_mem;
    logic [9:0] exp;
  } vec_t;

  function automatic logic [9:0] outs();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, exmem_flush, memwb_en, memwb_flush, halt};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; memtoReg_MEM = 1'b0; memWr_MEM = 1'b0;
    memtoReg_EX = 1'b0; rt_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
    PC_Src_MEM = 2'b00; zero_MEM = 1'b0; halt_MEM = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; memtoReg_MEM = v.mtr_mem; memWr_MEM = v.mw_mem;
    memtoReg_EX = v.mtr_ex; rt_EX = v.rt_ex; rs_ID = v.rs_id; rt_ID = v.rt_id;
    PC_Src_MEM = v.pcsrc; zero_MEM = v.zero; halt_MEM = v.halt_mem;
  endtask

  // Leaves the bench at posedge+1 with RST low and inputs idle.
  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  function automatic vec_t mk(input logic ih, input logic dh, input logic mtrm, input logic mwm,
                              input logic mtre, input logic [4:0] rte, input logic [4:0] rsi,
                              input logic [4:0] rti, input logic [1:0] pcs, input logic z,
                              input logic hm, input logic [9:0] e);
    vec_t v;
    v.ihit = ih; v.dhit = dh; v.mtr_mem = mtrm; v.mw_mem = mwm; v.mtr_ex = mtre;
    v.rt_ex = rte; v.rs_id = rsi; v.rt_id = rti; v.pcsrc = pcs; v.zero = z;
    v.halt_mem = hm; v.exp = e;
    return v;
  endfunction

  // Reference model state: abstract flags and counters, not an FSM encoding.
  bit m_halted;
  int m_drain_left;
  bit m_pending;
  int m_stall;

  function automatic bit m_busy();
    return (memtoReg_MEM || memWr_MEM) && !dhit;
  endfunction

  function automatic bit m_redir_now();
    return (PC_Src_MEM == 2'b01 && zero_MEM) || PC_Src_MEM == 2'b10 || PC_Src_MEM == 2'b11;
  endfunction

  function automatic logic [9:0] model_out();
    bit lu;
    lu = memtoReg_EX && rt_EX != 0 && (rt_EX == rs_ID || rt_EX == rt_ID);
    if (RST)                          return O_NONE;
    if (m_halted)                     return O_HALTED;
    if (m_drain_left > 0)             return O_DRAIN;
    if (m_busy())                     return O_NONE;
    if (halt_MEM)                     return O_DRAIN;
    if (m_pending || m_redir_now())   return O_REDIR;
    if (lu)                           return O_LDUSE;
    if (!ihit)                        return O_NOIHIT;
    return O_NORMAL;
  endfunction

  task automatic model_clock();
    logic [9:0] o;
    o = model_out();
    if (RST) begin
      m_halted = 0; m_drain_left = 0; m_pending = 0; m_stall = 0;
    end else if (m_halted) begin
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else begin
      if (!o[9] && m_stall < 65535) m_stall++;
      if (m_busy()) m_pending = m_pending || m_redir_now();
      else begin
        m_pending = 0;
        if (halt_MEM) m_drain_left = 2;
      end
    end
  endtask

  vec_t vecs[16];

  initial begin
    RST = 1'b1;
    idle_inputs();

    // ---- reset state ----
    @(posedge CLK); #1;
    @(negedge CLK);
    check("reset_outs", {6'd0, outs()}, {6'd0, O_NONE});
    check("reset_stall", stall_cnt, 16'd0);
    next_cycle();
    RST = 1'b0;
    @(negedge CLK);
    check("post_reset_outs", {6'd0, outs()}, {6'd0, O_NORMAL});

    // ---- directed vector table, each applied from a fresh RUN state ----
    vecs[0]  = mk(1,1,0,0, 0, 5'd0, 5'd0, 5'd0, 2'b00,0,0, O_NORMAL);
    vecs[1]  = mk(1,1,0,0, 1, 5'd5, 5'd5, 5'd1, 2'b00,0,0, O_LDUSE);
    vecs[2]  = mk(1,1,0,0, 1, 5'd7, 5'd2, 5'd7, 2'b00,0,0, O_LDUSE);
    vecs[3]  = mk(1,1,0,0, 1, 5'd0, 5'd0, 5'd0, 2'b00,0,0, O_NORMAL);
    vecs[4]  = mk(1,1,0,0, 0, 5'd0, 5'd0, 5'd0, 2'b01,1,0, O_REDIR);
    vecs[5]  = mk(1,1,0,0, 0, 5'd0, 5'd0, 5'd0, 2'b01,0,0, O_NORMAL);
    vecs[6]  = mk(1,1,0,0, 0, 5'd0, 5'd0, 5'd0, 2'b10,0,0, O_REDIR);
    vecs[7]  = mk(1,1,0,0, 0, 5'd0, 5'd0, 5'd0, 2'b11,0,0, O_REDIR);
    vecs[8]  = mk(0,1,0,0, 0, 5'd0, 5'd0, 5'd0, 2'b00,0,0, O_NOIHIT);
    vecs[9]  = mk(1,0,1,0, 0, 5'd0, 5'd0, 5'd0, 2'b00,0,0, O_NONE);
    vecs[10] = mk(1,1,0,1, 0, 5'd0, 5'd0, 5'd0, 2'b00,0,0, O_NORMAL);
    vecs[11] = mk(1,1,0,0, 0, 5'd0, 5'd0, 5'd0, 2'b00,0,1, O_DRAIN);
    vecs[12] = mk(1,1,0,0, 0, 5'd0, 5'd0, 5'd0, 2'b10,0,1, O_DRAIN);
    vecs[13] = mk(1,1,0,0, 1, 5'd3, 5'd3, 5'd0, 2'b11,0,0, O_REDIR);
    vecs[14] = mk(0,1,0,0, 1, 5'd4, 5'd0, 5'd4, 2'b00,0,0, O_LDUSE);
    vecs[15] = mk(1,0,0,1, 0, 5'd0, 5'd0, 5'd0, 2'b10,0,1, O_NONE);
    for (int i = 0; i < 16; i++) begin
      do_reset();
      apply(vecs[i]);
      @(negedge CLK);
      check($sformatf("vec%0d", i), {6'd0, outs()}, {6'd0, vecs[i].exp});
    end

    // ---- load-use: one stall cycle, counter 1 ----
    do_reset();
    memtoReg_EX = 1; rt_EX = 5'd5; rs_ID = 5'd5;
    @(negedge CLK);
    check("lu_outs", {6'd0, outs()}, {6'd0, O_LDUSE});
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    check("lu_resume", {6'd0, outs()}, {6'd0, O_NORMAL});
    check("lu_stall_cnt", stall_cnt, 16'd1);

    // ---- memory wait: 3 frozen cycles then RUN outputs ----
    do_reset();
    memtoReg_MEM = 1; dhit = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check($sformatf("mw_freeze%0d", c), {6'd0, outs()}, {6'd0, O_NONE});
      next_cycle();
    end
    dhit = 1;
    @(negedge CLK);
    check("mw_release", {6'd0, outs()}, {6'd0, O_NORMAL});
    check("mw_stall_cnt", stall_cnt, 16'd3);
    next_cycle();
    idle_inputs();
    @(negedge CLK);
    check("mw_stall_hold", stall_cnt, 16'd3);

    // ---- redirect during memory wait ----
    do_reset();
    memWr_MEM = 1; dhit = 0; PC_Src_MEM = 2'b10;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check($sformatf("rw_freeze%0d", c), {6'd0, outs()}, {6'd0, O_NONE});
      next_cycle();
    end
    dhit = 1;
    @(negedge CLK);
    check("rw_release", {6'd0, outs()}, {6'd0, O_REDIR});

    // ---- halt: drain 2 cycles, halted, then reset ----
    do_reset();
    halt_MEM = 1;
    @(negedge CLK);
    check("halt_req", {6'd0, outs()}, {6'd0, O_DRAIN});
    next_cycle();
    halt_MEM = 0; memtoReg_MEM = 1; dhit = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check($sformatf("drain%0d", c), {6'd0, outs()}, {6'd0, O_DRAIN});
      next_cycle();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check($sformatf("halted%0d", c), {6'd0, outs()}, {6'd0, O_HALTED});
      next_cycle();
    end
    check("halt_stall_cnt", stall_cnt, 16'd1);
    RST = 1;
    @(negedge CLK);
    check("halted_rst", {6'd0, outs()}, {6'd0, O_NONE});
    next_cycle();
    RST = 0; idle_inputs();
    @(negedge CLK);
    check("halt_back_run", {6'd0, outs()}, {6'd0, O_NORMAL});

    // ---- reset aborts DRAIN with no residual flush ----
    halt_MEM = 1;
    next_cycle();
    halt_MEM = 0;
    RST = 1;
    @(negedge CLK);
    check("drain_rst", {6'd0, outs()}, {6'd0, O_NONE});
    next_cycle();
    RST = 0;
    @(negedge CLK);
    check("drain_rst_run", {6'd0, outs()}, {6'd0, O_NORMAL});

    // ---- randomized run against the reference model ----
    RST = 1;
    idle_inputs();
    m_halted = 0; m_drain_left = 0; m_pending = 0; m_stall = 0;
    for (int n = 0; n < 3000; n++) begin
      RST          = ($urandom_range(99) < 2) || n == 0;
      ihit         = $urandom_range(99) < 80;
      dhit         = $urandom_range(99) < 55;
      memtoReg_MEM = $urandom_range(99) < 25;
      memWr_MEM    = $urandom_range(99) < 15;
      memtoReg_EX  = $urandom_range(99) < 40;
      rt_EX        = 5'($urandom_range(3));
      rs_ID        = 5'($urandom_range(3));
      rt_ID        = 5'($urandom_range(3));
      PC_Src_MEM   = 2'($urandom_range(3));
      zero_MEM     = 1'($urandom_range(1));
      halt_MEM     = $urandom_range(99) < 3;
      @(negedge CLK);
      check($sformatf("rnd%0d_outs", n), {6'd0, outs()}, {6'd0, model_out()});
      check($sformatf("rnd%0d_stall", n), stall_cnt, 16'(m_stall));
      model_clock();
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
